// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter width needed to index N bit positions (never narrower than 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester (master) and the serial
// subtractor (slave).
interface serial_subtractor_if #(
    parameter int unsigned N = 8
) ();

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, ovf
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow when y exceeds x, or when they are equal and a borrow arrives.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per cycle, LSB
// first, over N RUN cycles, then pulses done for one cycle.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CW = cnt_width(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            br_q, br_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bo_q, bo_d;
    logic            ovf_q, ovf_d;

    logic            ai;
    logic            bi;
    logic            d_bit;
    logic            br_next;
    logic            accept;
    logic            last_bit;

    // Current bit position of the latched operands.
    assign ai = a_q[cnt_q];
    assign bi = b_q[cnt_q];

    full_subtractor u_fs (
        .x    (ai),
        .y    (bi),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_next)
    );

    assign accept   = (state_q == StIdle) && bus.start;
    assign last_bit = (state_q == StRun) && (cnt_q == CW'(N - 1));

    // Next-state logic and status outputs.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                bus.busy = 1'b1;
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state: latch on accept, shift one result bit per RUN cycle.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        diff_d = diff_q;
        bo_d   = bo_q;
        ovf_d  = ovf_q;
        if (accept) begin
            cnt_d = '0;
            a_d   = bus.a;
            b_d   = bus.b;
            br_d  = bus.borrow_in;
        end else if (state_q == StRun) begin
            cnt_d  = cnt_q + 1'b1;
            br_d   = br_next;
            // New bit enters at the MSB so the word is aligned after N shifts.
            diff_d = {d_bit, diff_q[N-1:1]};
            if (last_bit) begin
                bo_d  = br_next;
                // d_bit is the result MSB on the final RUN cycle.
                ovf_d = (a_q[N-1] != b_q[N-1]) && (d_bit != a_q[N-1]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            diff_q <= diff_d;
            bo_q   <= bo_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;
    assign bus.ovf        = ovf_q;

endmodule
